product_accumulator64: RTL and testbench

//  Downstream stage of the 64-bit multiplier control system. Consumes the product stream
//  (xy qualified by the multiplier's done_sig) and accumulates a programmed number of

---
 rtl/product_accumulator64.sv | 122 ++++++++++++
 tb/tb_product_accumulator64.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator64.sv
// ============================================================================
// Module   : product_accumulator64
// Purpose  : Accumulates a programmed number of signed products into one
//            saturated sum with a done pulse and a sticky overflow flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module product_accumulator64 #(
    parameter int WIDTH = 64,
    parameter int GUARD = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sta,
    input  logic [CNT_W-1:0] len,
    input  logic             xy_valid,
    input  logic [WIDTH-1:0] xy,
    output logic [WIDTH-1:0] sum,
    output logic             done_sig,
    output logic             busy,
    output logic             ovf
);

    localparam int AW = WIDTH + GUARD;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [WIDTH-1:0] C_SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] C_SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state_q, state_d;
    logic [AW-1:0]    acc_q,   acc_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [CNT_W-1:0] len_q,   len_d;
    logic [WIDTH-1:0] sum_q,   sum_d;
    logic             ovf_q,   ovf_d;

    logic [AW-1:0]    w_acc_next;
    logic [GUARD:0]   w_top_bits;
    logic             w_in_range;
    logic             w_last;
    logic [WIDTH-1:0] w_sat_val;

    assign w_acc_next = acc_q + {{GUARD{xy[WIDTH-1]}}, xy};

    // The result fits in WIDTH bits only when the guard bits all replicate its sign bit.
    assign w_top_bits = w_acc_next[AW-1:WIDTH-1];
    assign w_in_range = (&w_top_bits) | ~(|w_top_bits);
    assign w_sat_val  = w_in_range ? w_acc_next[WIDTH-1:0]
                      : (w_acc_next[AW-1] ? C_SAT_NEG : C_SAT_POS);

    assign w_last = (cnt_q == (len_q - CNT_W'(1)));

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (sta) begin
                    ovf_d = 1'b0;
                    if (len != '0) begin
                        acc_d   = '0;
                        cnt_d   = '0;
                        len_d   = len;
                        state_d = S_ACCUM;
                    end else begin
                        sum_d   = '0;
                        state_d = S_DONE;
                    end
                end
            end
            S_ACCUM: begin
                if (xy_valid) begin
                    if (w_last) begin
                        sum_d   = w_sat_val;
                        ovf_d   = ~w_in_range;
                        state_d = S_DONE;
                    end else begin
                        acc_d = w_acc_next;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum      = sum_q;
    assign ovf      = ovf_q;
    assign done_sig = (state_q == S_DONE);
    assign busy     = (state_q == S_ACCUM);

endmodule

`default_nettype wire

// File: tb/tb_product_accumulator64.sv
// ============================================================================
// Module   : tb_product_accumulator64
// Purpose  : Self-checking bench for product_accumulator64 with a numeric
//            reference model of the saturated accumulation.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_product_accumulator64;

    logic        clk;
    logic        rst;
    logic        sta;
    logic [15:0] len;
    logic        xy_valid;
    logic [63:0] xy;
    logic [63:0] sum;
    logic        done_sig;
    logic        busy;
    logic        ovf;

    int errors;
    int checks;

    logic [63:0] prods [16];

    localparam logic signed [71:0] LIM_HI = 72'sh00_7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [71:0] LIM_LO = 72'shFF_8000_0000_0000_0000;
    localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;

    product_accumulator64 dut (
        .clk      (clk),
        .rst      (rst),
        .sta      (sta),
        .len      (len),
        .xy_valid (xy_valid),
        .xy       (xy),
        .sum      (sum),
        .done_sig (done_sig),
        .busy     (busy),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Exact sum in a wide signed integer, then clamp to the 64-bit signed range.
    function automatic logic [64:0] model_result(input int n);
        logic signed [71:0] total;
        total = '0;
        for (int i = 0; i < n; i++)
            total = total + $signed({{8{prods[i][63]}}, prods[i]});
        if (total > LIM_HI) return {1'b1, MAXP};
        if (total < LIM_LO) return {1'b1, MINN};
        return {1'b0, total[63:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int n);
        sta = 1'b1;
        len = 16'(n);
        tick();
        sta = 1'b0;
    endtask

    task automatic feed(input logic [63:0] v, input int gap, input bit noisy);
        for (int g = 0; g < gap; g++) begin
            xy_valid = 1'b0;
            xy       = {$urandom, $urandom};
            if (noisy) begin
                sta = 1'($urandom_range(0, 1));
                len = 16'($urandom_range(0, 5));
            end
            tick();
        end
        xy_valid = 1'b1;
        xy       = v;
        if (noisy) sta = 1'($urandom_range(0, 1));
        tick();
        xy_valid = 1'b0;
        sta      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (sum !== 64'h0 || done_sig !== 1'b0 || busy !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got sum=%h done=%b busy=%b ovf=%b expected all zero",
                     sum, done_sig, busy, ovf);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [63:0] vals [4];
        vals[0] = 64'd3;
        vals[1] = -64'sd5;
        vals[2] = 64'd10;
        vals[3] = 64'd7;
        start(4);
        for (int i = 0; i < 4; i++) begin
            feed(vals[i], (i * 2) % 7 + (i == 3 ? 6 - 6 : 0), 1'b0);
            if (i < 3) begin
                checks++;
                if (busy !== 1'b1 || done_sig !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_midway[%0d]: got busy=%b done=%b expected busy=1 done=0",
                             i, busy, done_sig);
                end
            end
        end
        checks++;
        if (done_sig !== 1'b1 || sum !== 64'd15 || ovf !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: got done=%b sum=%0d ovf=%b busy=%b expected done=1 sum=15 ovf=0 busy=0",
                     done_sig, $signed(sum), ovf, busy);
        end
        tick();
        checks++;
        if (done_sig !== 1'b0 || sum !== 64'd15) begin
            errors++;
            $display("FAIL basic_pulse_width: got done=%b sum=%0d expected done=0 sum=15",
                     done_sig, $signed(sum));
        end
    endtask

    task automatic test_reset_mid_accum();
        start(4);
        feed(64'd20, 1, 1'b0);
        feed(64'd30, 0, 1'b0);
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        checks++;
        if (sum !== 64'h0 || busy !== 1'b0 || done_sig !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_accum: got sum=%h busy=%b done=%b ovf=%b expected zeros",
                     sum, busy, done_sig, ovf);
        end
        xy_valid = 1'b1;
        xy       = 64'd40;
        tick();
        tick();
        xy_valid = 1'b0;
        checks++;
        if (done_sig !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done: got done=%b busy=%b expected 0 0", done_sig, busy);
        end
        start(2);
        feed(64'd5, 0, 1'b0);
        feed(64'd6, 2, 1'b0);
        checks++;
        if (done_sig !== 1'b1 || sum !== 64'd11) begin
            errors++;
            $display("FAIL reset_restart: got done=%b sum=%0d expected done=1 sum=11",
                     done_sig, $signed(sum));
        end
        tick();
    endtask

    task automatic test_len_zero();
        start(0);
        checks++;
        if (done_sig !== 1'b1 || sum !== 64'h0 || busy !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL len_zero: got done=%b sum=%h busy=%b ovf=%b expected done=1 sum=0 busy=0 ovf=0",
                     done_sig, sum, busy, ovf);
        end
        tick();
        checks++;
        if (done_sig !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL len_zero_after: got done=%b busy=%b expected 0 0", done_sig, busy);
        end
    endtask

    task automatic test_saturation();
        start(2);
        feed(MAXP, 0, 1'b0);
        feed(MAXP, 3, 1'b0);
        checks++;
        if (done_sig !== 1'b1 || sum !== MAXP || ovf !== 1'b1) begin
            errors++;
            $display("FAIL sat_pos: got done=%b sum=%h ovf=%b expected done=1 sum=%h ovf=1",
                     done_sig, sum, ovf, MAXP);
        end
        tick();
        start(2);
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got ovf=%b expected 0", ovf);
        end
        feed(MINN, 1, 1'b0);
        feed(MINN, 0, 1'b0);
        checks++;
        if (done_sig !== 1'b1 || sum !== MINN || ovf !== 1'b1) begin
            errors++;
            $display("FAIL sat_neg: got done=%b sum=%h ovf=%b expected done=1 sum=%h ovf=1",
                     done_sig, sum, ovf, MINN);
        end
        tick();
        start(3);
        feed(MAXP, 0, 1'b0);
        feed(MAXP, 0, 1'b0);
        feed(MINN, 2, 1'b0);
        checks++;
        if (sum !== 64'h7FFF_FFFF_FFFF_FFFE || ovf !== 1'b0) begin
            errors++;
            $display("FAIL sat_intermediate: got sum=%h ovf=%b expected 7ffffffffffffffe ovf=0",
                     sum, ovf);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        start(3);
        sta = 1'b1;
        len = 16'd1;
        xy_valid = 1'b1;
        xy = 64'd100;
        tick();
        xy = 64'd200;
        tick();
        xy_valid = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b1 || done_sig !== 1'b0) begin
            errors++;
            $display("FAIL sta_ignored_busy: got busy=%b done=%b expected busy=1 done=0",
                     busy, done_sig);
        end
        xy_valid = 1'b1;
        xy = 64'd300;
        tick();
        xy_valid = 1'b0;
        sta = 1'b0;
        checks++;
        if (done_sig !== 1'b1 || sum !== 64'd600) begin
            errors++;
            $display("FAIL sta_ignored_sum: got done=%b sum=%0d expected done=1 sum=600",
                     done_sig, $signed(sum));
        end
        start(2);
        checks++;
        if (busy !== 1'b1 || done_sig !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: got busy=%b done=%b expected busy=1 done=0",
                     busy, done_sig);
        end
        feed(-64'sd7, 0, 1'b0);
        feed(-64'sd8, 1, 1'b0);
        checks++;
        if (done_sig !== 1'b1 || sum !== -64'sd15 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL b2b_sum: got done=%b sum=%0d ovf=%b expected done=1 sum=-15 ovf=0",
                     done_sig, $signed(sum), ovf);
        end
        tick();
    endtask

    task automatic test_ignored_strobes();
        xy_valid = 1'b1;
        xy = 64'd99;
        tick();
        tick();
        sta = 1'b1;
        len = 16'd1;
        tick();
        sta = 1'b0;
        xy_valid = 1'b0;
        feed(-64'sd1, 1, 1'b0);
        checks++;
        if (done_sig !== 1'b1 || sum !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++;
            $display("FAIL idle_strobe_excluded: got done=%b sum=%h expected done=1 sum=ffffffffffffffff",
                     done_sig, sum);
        end
        xy_valid = 1'b1;
        xy = 64'd99;
        tick();
        xy_valid = 1'b0;
        checks++;
        if (done_sig !== 1'b0 || busy !== 1'b0 || sum !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++;
            $display("FAIL done_strobe_excluded: got done=%b busy=%b sum=%h expected 0 0 ffffffffffffffff",
                     done_sig, busy, sum);
        end
    endtask

    task automatic test_random();
        logic [64:0] expv;
        bit          in_done;
        int          n;
        in_done = 1'b0;
        for (int t = 0; t < 40; t++) begin
            n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 3))
                    0: prods[i] = {{48{1'b0}}, 16'($urandom)} - 64'd32768;
                    1: prods[i] = {$urandom, $urandom};
                    2: prods[i] = MAXP - 64'($urandom_range(0, 3));
                    default: prods[i] = MINN + 64'($urandom_range(0, 3));
                endcase
            end
            expv = model_result(n);
            if (!(in_done && $urandom_range(0, 1) == 1)) begin
                repeat ($urandom_range(1, 3)) tick();
            end
            start(n);
            for (int i = 0; i < n; i++)
                feed(prods[i], int'($urandom_range(0, 3)), 1'b1);
            checks++;
            if (done_sig !== 1'b1 || busy !== 1'b0 || sum !== expv[63:0] || ovf !== expv[64]) begin
                errors++;
                $display("FAIL random[%0d] len=%0d: got done=%b busy=%b sum=%h ovf=%b expected done=1 busy=0 sum=%h ovf=%b",
                         t, n, done_sig, busy, sum, ovf, expv[63:0], expv[64]);
            end
            in_done = 1'b1;
        end
        tick();
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        rst      = 1'b0;
        sta      = 1'b0;
        len      = '0;
        xy_valid = 1'b0;
        xy       = '0;
        test_reset();
        test_basic();
        test_reset_mid_accum();
        test_len_zero();
        test_saturation();
        test_back_to_back();
        test_ignored_strobes();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
